// File: rtl/fifo_multichannel_rr_drain.sv
// Round-robin drain of first-word-fall-through FIFO channels into one tagged
// valid/ready stream, with grants bounded to MAX_BURST pops each.
`timescale 1ns/1ps
module fifo_multichannel_rr_drain #(
    parameter int RAM_WIDTH = 32,
    parameter int FIFOS_CNT = 50,
    parameter int MAX_BURST = 4
) (
    input  logic                                clk,
    input  logic                                rst_all,
    input  logic [FIFOS_CNT-1:0]                i_channel_en,
    input  logic [FIFOS_CNT-1:0]                i_rd_valid_channels,
    input  logic [FIFOS_CNT-1:0][RAM_WIDTH-1:0] i_rd_data_channels,
    output logic [FIFOS_CNT-1:0]                o_rd_en_channels,
    output logic                                o_valid,
    output logic [RAM_WIDTH-1:0]                o_data,
    output logic [$clog2(FIFOS_CNT)-1:0]        o_channel_id,
    input  logic                                i_ready,
    output logic [FIFOS_CNT-1:0]                o_grant_channels,
    output logic                                o_busy
);
    localparam int ID_W   = $clog2(FIFOS_CNT);
    localparam int BCNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [ID_W-1:0]   LAST_CH    = ID_W'(FIFOS_CNT - 1);
    localparam logic [BCNT_W-1:0] BURST_LAST = BCNT_W'(MAX_BURST - 1);
    localparam logic [ID_W:0]     CH_CNT     = (ID_W + 1)'(FIFOS_CNT);

    typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t                 state_r, state_s;
    logic [ID_W-1:0]        grant_r, grant_s;
    logic [ID_W-1:0]        rr_ptr_r, rr_ptr_s;
    logic [BCNT_W-1:0]      burst_cnt_r, burst_cnt_s;
    logic                   valid_r, valid_s;
    logic [RAM_WIDTH-1:0]   data_r, data_s;
    logic [ID_W-1:0]        id_r, id_s;
    logic [FIFOS_CNT-1:0]   grant_oh_r, grant_oh_s;
    logic                   busy_r, busy_s;
    logic [FIFOS_CNT-1:0]   eligible_s;
    logic [FIFOS_CNT-1:0]   rd_en_s;
    logic                   found_s;
    logic [ID_W-1:0]        pick_s;
    logic                   pop_s;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] ch);
        if (ch == LAST_CH) begin
            return '0;
        end else begin
            return ch + ID_W'(1);
        end
    endfunction

    assign eligible_s = i_rd_valid_channels & i_channel_en;
    // Pops are never issued while reset is held, whatever the old state was.
    assign pop_s = ~rst_all & (state_r == BURST) & eligible_s[grant_r] & (~valid_r | i_ready);

    // First eligible channel at or above rr_ptr, wrapping past the last channel.
    always_comb begin
        logic [ID_W:0] cand_v;
        found_s = 1'b0;
        pick_s  = '0;
        cand_v  = '0;
        for (int k = 0; k < FIFOS_CNT; k++) begin
            cand_v = {1'b0, rr_ptr_r} + (ID_W + 1)'(k);
            if (cand_v >= CH_CNT) begin
                cand_v = cand_v - CH_CNT;
            end else begin
                cand_v = cand_v;
            end
            if (!found_s && eligible_s[cand_v[ID_W-1:0]]) begin
                found_s = 1'b1;
                pick_s  = cand_v[ID_W-1:0];
            end else begin
                pick_s  = pick_s;
            end
        end
    end

    // Pop strobe toward the granted FIFO; combinational so a word leaves per cycle.
    always_comb begin
        rd_en_s          = '0;
        rd_en_s[grant_r] = pop_s;
    end

    assign o_rd_en_channels = rd_en_s;

    // Next-state, burst accounting and next output-register contents.
    always_comb begin
        state_s     = state_r;
        grant_s     = grant_r;
        rr_ptr_s    = rr_ptr_r;
        burst_cnt_s = burst_cnt_r;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    grant_s     = pick_s;
                    burst_cnt_s = '0;
                    state_s     = BURST;
                end else begin
                    state_s     = IDLE;
                end
            end
            BURST: begin
                if (!eligible_s[grant_r]) begin
                    rr_ptr_s    = wrap_inc(grant_r);
                    burst_cnt_s = '0;
                    state_s     = IDLE;
                end else if (pop_s && (burst_cnt_r == BURST_LAST)) begin
                    rr_ptr_s    = wrap_inc(grant_r);
                    burst_cnt_s = '0;
                    state_s     = IDLE;
                end else if (pop_s) begin
                    burst_cnt_s = burst_cnt_r + BCNT_W'(1);
                end else begin
                    state_s     = BURST;
                end
            end
            default: begin
                state_s     = IDLE;
                burst_cnt_s = '0;
            end
        endcase

        valid_s = valid_r;
        data_s  = data_r;
        id_s    = id_r;
        if (pop_s) begin
            valid_s = 1'b1;
            data_s  = i_rd_data_channels[grant_r];
            id_s    = grant_r;
        end else if (valid_r && i_ready) begin
            valid_s = 1'b0;
        end else begin
            valid_s = valid_r;
        end

        grant_oh_s = '0;
        if (state_s == BURST) begin
            grant_oh_s[grant_s] = 1'b1;
        end else begin
            grant_oh_s = '0;
        end
        busy_s = (state_s == BURST) | valid_s;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_all) begin
            state_r     <= IDLE;
            grant_r     <= '0;
            rr_ptr_r    <= '0;
            burst_cnt_r <= '0;
            valid_r     <= 1'b0;
            data_r      <= '0;
            id_r        <= '0;
            grant_oh_r  <= '0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            grant_r     <= grant_s;
            rr_ptr_r    <= rr_ptr_s;
            burst_cnt_r <= burst_cnt_s;
            valid_r     <= valid_s;
            data_r      <= data_s;
            id_r        <= id_s;
            grant_oh_r  <= grant_oh_s;
            busy_r      <= busy_s;
        end
    end

    assign o_valid          = valid_r;
    assign o_data           = data_r;
    assign o_channel_id     = id_r;
    assign o_grant_channels = grant_oh_r;
    assign o_busy           = busy_r;

endmodule

// File: tb/tb_fifo_multichannel_rr_drain.sv
// Bench for fifo_multichannel_rr_drain: FWFT FIFO model driven by the DUT pop
// strobes, plus a transaction-level scheduler reference model.
`timescale 1ns/1ps
module tb_fifo_multichannel_rr_drain;
    localparam int W   = 32;
    localparam int N   = 50;
    localparam int MB  = 4;
    localparam int IDW = $clog2(N);
    localparam int VW  = 2 * N + 1 + W + IDW + 1;
    localparam int DEPTH = 256;

    logic                clk = 1'b0;
    logic                rst_all;
    logic [N-1:0]        i_channel_en;
    logic [N-1:0]        i_rd_valid_channels;
    logic [N-1:0][W-1:0] i_rd_data_channels;
    logic [N-1:0]        o_rd_en_channels;
    logic                o_valid;
    logic [W-1:0]        o_data;
    logic [IDW-1:0]      o_channel_id;
    logic                i_ready;
    logic [N-1:0]        o_grant_channels;
    logic                o_busy;

    fifo_multichannel_rr_drain #(.RAM_WIDTH(W), .FIFOS_CNT(N), .MAX_BURST(MB)) dut (
        .clk                 (clk),
        .rst_all             (rst_all),
        .i_channel_en        (i_channel_en),
        .i_rd_valid_channels (i_rd_valid_channels),
        .i_rd_data_channels  (i_rd_data_channels),
        .o_rd_en_channels    (o_rd_en_channels),
        .o_valid             (o_valid),
        .o_data              (o_data),
        .o_channel_id        (o_channel_id),
        .i_ready             (i_ready),
        .o_grant_channels    (o_grant_channels),
        .o_busy              (o_busy)
    );

    always #5 clk = ~clk;

    // FIFO contents; head advances on DUT pops, mhead on reference-model pops.
    logic [W-1:0] mem [N][DEPTH];
    int head [N];
    int tail [N];
    int mhead [N];

    // Reference model: current grant (-1 = none), pops left, rr pointer, output word.
    int           mg = -1;
    int           mleft = 0;
    int           mrr = 0;
    logic         mv = 1'b0;
    logic [W-1:0] md = '0;
    logic [IDW-1:0] mid = '0;

    logic [VW-1:0]  exp_v, obs_v;
    logic [N-1:0]   obs_rd, obs_gr;
    logic           obs_valid, obs_busy;
    logic [W-1:0]   obs_data;
    logic [IDW-1:0] obs_id;
    logic           acc_valid;
    logic [W-1:0]   acc_data;
    logic [IDW-1:0] acc_id;

    int checks = 0;
    int failures = 0;

    task automatic push(input int c, input logic [W-1:0] v);
        if (tail[c] < DEPTH) begin
            mem[c][tail[c]] = v;
            tail[c]++;
        end
    endtask

    task automatic flush();
        for (int c = 0; c < N; c++) begin
            head[c] = 0;
            tail[c] = 0;
            mhead[c] = 0;
        end
    endtask

    function automatic bit drained();
        for (int c = 0; c < N; c++) begin
            if (head[c] != tail[c]) return 1'b0;
        end
        return !mv && (mg < 0);
    endfunction

    function automatic logic [N-1:0] onehot(input int c);
        logic [N-1:0] one_v;
        one_v = 1;
        return one_v << c;
    endfunction

    // One clock: present FIFO heads, sample DUT and model, then advance both.
    task automatic step();
        logic [N-1:0] elig, exp_rd, exp_gr;
        logic m_pop;
        bit found;
        int cand;
        @(negedge clk);
        for (int c = 0; c < N; c++) begin
            i_rd_valid_channels[c] = (head[c] < tail[c]);
            i_rd_data_channels[c]  = (head[c] < tail[c]) ? mem[c][head[c]] : {16'hdead, 16'(c)};
        end
        #1;
        elig   = i_rd_valid_channels & i_channel_en;
        m_pop  = !rst_all && (mg >= 0) && elig[mg] && (!mv || i_ready);
        exp_gr = (mg >= 0) ? onehot(mg) : '0;
        exp_rd = m_pop ? exp_gr : '0;
        exp_v  = {exp_rd, exp_gr, mv, md, mid, (mg >= 0) || mv};
        obs_rd = o_rd_en_channels;
        obs_gr = o_grant_channels;
        obs_valid = o_valid;
        obs_data  = o_data;
        obs_id    = o_channel_id;
        obs_busy  = o_busy;
        obs_v     = {obs_rd, obs_gr, obs_valid, obs_data, obs_id, obs_busy};
        acc_valid = o_valid && i_ready && !rst_all;
        acc_data  = o_data;
        acc_id    = o_channel_id;
        @(posedge clk);
        if (rst_all) begin
            mg = -1; mleft = 0; mrr = 0; mv = 1'b0; md = '0; mid = '0;
        end else begin
            if (m_pop) begin
                md = mem[mg][mhead[mg]];
                mhead[mg]++;
                mid = IDW'(mg);
                mv = 1'b1;
            end else if (mv && i_ready) begin
                mv = 1'b0;
            end
            if (mg < 0) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    cand = (mrr + k) % N;
                    if (!found && elig[cand]) begin
                        found = 1'b1;
                        mg = cand;
                        mleft = MB;
                    end
                end
            end else if (!elig[mg]) begin
                mrr = (mg + 1) % N;
                mg = -1;
            end else if (m_pop) begin
                mleft--;
                if (mleft == 0) begin
                    mrr = (mg + 1) % N;
                    mg = -1;
                end
            end
        end
        for (int c = 0; c < N; c++) begin
            if (obs_rd[c] && head[c] < tail[c]) head[c]++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_all = 1'b1;
        repeat (2) step();
        flush();
    endtask

    task automatic test_reset();
        int lowest;
        lowest = -1;
        rst_all = 1'b1;
        i_ready = 1'b1;
        i_channel_en = '1;
        flush();
        for (int j = 0; j < 5; j++) begin
            int c;
            c = $urandom_range(3, N - 1);
            for (int k = 0; k < 3; k++) push(c, $urandom);
        end
        for (int c = N - 1; c >= 0; c--) if (tail[c] > 0) lowest = c;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i > 0) begin
                checks++;
                if (obs_v !== '0) begin
                    failures++;
                    $display("FAIL reset_outputs cyc=%0d got=%h exp=0", i, obs_v);
                end
            end
        end
        rst_all = 1'b0;
        step();
        step();
        checks++;
        if (obs_gr !== onehot(lowest)) begin
            failures++;
            $display("FAIL reset_first_grant got=%h exp=%h", obs_gr, onehot(lowest));
        end
        for (int i = 0; i < 400 && !drained(); i++) begin
            step();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL reset_drain cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
            end
        end
        checks++;
        if (!drained()) begin
            failures++;
            $display("FAIL reset_drain_timeout got=not_drained exp=drained");
        end
    endtask

    task automatic test_single_channel();
        logic         vseq [40];
        logic [W-1:0] dseq [40];
        logic [IDW-1:0] iseq [40];
        int first, nvalid, b, r, word;
        logic expv;
        do_reset();
        for (int k = 1; k <= 10; k++) push(3, W'(k));
        rst_all = 1'b0;
        i_ready = 1'b1;
        first = -1;
        nvalid = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL single_model cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
            end
            vseq[i] = acc_valid;
            dseq[i] = acc_data;
            iseq[i] = acc_id;
            if (acc_valid) nvalid++;
            if (acc_valid && first < 0) first = i;
        end
        checks++;
        if (first != 2) begin
            failures++;
            $display("FAIL single_latency got=%0d exp=2", first);
        end
        if (first >= 0 && first + 15 <= 40) begin
            for (int p = 0; p < 15; p++) begin
                b = p / (MB + 1);
                r = p % (MB + 1);
                word = b * MB + r + 1;
                expv = (r < MB) && (word <= 10);
                checks++;
                if (vseq[first + p] !== expv || (expv && (dseq[first + p] !== W'(word) || iseq[first + p] !== IDW'(3)))) begin
                    failures++;
                    $display("FAIL single_stream pos=%0d got=v%0b d%0d id%0d exp=v%0b d%0d id3",
                             p, vseq[first + p], dseq[first + p], iseq[first + p], expv, word);
                end
            end
        end
        checks++;
        if (nvalid != 10 || head[3] != tail[3]) begin
            failures++;
            $display("FAIL single_fill got=words%0d fill%0d exp=words10 fill0", nvalid, tail[3] - head[3]);
        end
    endtask

    task automatic test_round_robin_wrap();
        int glog [$];
        int pops [$];
        int dcnt [N];
        int exp_order [6];
        exp_order = '{0, 1, 49, 0, 1, 49};
        do_reset();
        for (int c = 0; c < N; c++) dcnt[c] = 0;
        for (int k = 0; k < 8; k++) begin
            push(0, {8'd0, 24'(k)});
            push(1, {8'd1, 24'(k)});
            push(49, {8'd49, 24'(k)});
        end
        rst_all = 1'b0;
        i_ready = 1'b1;
        for (int i = 0; i < 120 && !drained(); i++) begin
            logic [N-1:0] prev_gr;
            prev_gr = (i == 0) ? '0 : obs_gr;
            step();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL rr_model cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
            end
            if (obs_gr != '0 && prev_gr == '0) begin
                for (int c = 0; c < N; c++) if (obs_gr[c]) glog.push_back(c);
                pops.push_back(0);
            end
            if (obs_rd != '0 && pops.size() > 0) pops[pops.size() - 1]++;
            if (acc_valid && int'(acc_id) < N) begin
                checks++;
                if (acc_data !== mem[acc_id][dcnt[acc_id]]) begin
                    failures++;
                    $display("FAIL rr_order ch=%0d got=%h exp=%h", acc_id, acc_data, mem[acc_id][dcnt[acc_id]]);
                end
                dcnt[acc_id]++;
            end
        end
        checks++;
        if (glog.size() != 6) begin
            failures++;
            $display("FAIL rr_grant_count got=%0d exp=6", glog.size());
        end else begin
            for (int j = 0; j < 6; j++) begin
                checks++;
                if (glog[j] != exp_order[j] || pops[j] != MB) begin
                    failures++;
                    $display("FAIL rr_grant idx=%0d got=ch%0d pops%0d exp=ch%0d pops%0d", j, glog[j], pops[j], exp_order[j], MB);
                end
            end
        end
        checks++;
        if (dcnt[0] != 8 || dcnt[1] != 8 || dcnt[49] != 8) begin
            failures++;
            $display("FAIL rr_delivered got=%0d,%0d,%0d exp=8,8,8", dcnt[0], dcnt[1], dcnt[49]);
        end
    endtask

    task automatic test_backpressure();
        int k;
        do_reset();
        for (int j = 0; j < 8; j++) push(10, $urandom);
        rst_all = 1'b0;
        i_ready = 1'b1;
        k = 0;
        for (int i = 0; i < 20 && k < 2; i++) begin
            step();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL bp_model cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
            end
            if (acc_valid) k++;
        end
        i_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (obs_valid !== 1'b1 || obs_data !== mem[10][k] || obs_id !== IDW'(10)
                || obs_rd !== '0 || obs_gr !== onehot(10)) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got=v%0b d%h id%0d rd%h gr%h exp=v1 d%h id10 rd0 gr%h",
                         i, obs_valid, obs_data, obs_id, obs_rd, obs_gr, mem[10][k], onehot(10));
            end
        end
        i_ready = 1'b1;
        for (int i = 0; i < 30 && !drained(); i++) begin
            step();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL bp_resume_model cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
            end
            if (acc_valid) begin
                checks++;
                if (acc_data !== mem[10][k]) begin
                    failures++;
                    $display("FAIL bp_resume word=%0d got=%h exp=%h", k, acc_data, mem[10][k]);
                end
                k++;
            end
        end
        checks++;
        if (k != 8) begin
            failures++;
            $display("FAIL bp_count got=%0d exp=8", k);
        end
    endtask

    task automatic test_disable_mid_burst();
        int p2, newg;
        bit resumed;
        do_reset();
        for (int j = 0; j < 6; j++) push(2, $urandom);
        for (int j = 0; j < 3; j++) push(5, $urandom);
        rst_all = 1'b0;
        i_ready = 1'b1;
        i_channel_en = '1;
        p2 = 0;
        for (int i = 0; i < 20 && p2 < 2; i++) begin
            step();
            if (obs_rd[2]) p2++;
        end
        i_channel_en[2] = 1'b0;
        newg = -1;
        for (int i = 0; i < 30 && (head[5] != tail[5] || mv || mg >= 0); i++) begin
            step();
            checks++;
            if (obs_v !== exp_v || obs_rd[2] !== 1'b0) begin
                failures++;
                $display("FAIL disable_model cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
            end
            if (newg < 0 && obs_gr != '0 && obs_gr != onehot(2)) begin
                for (int c = 0; c < N; c++) if (obs_gr[c]) newg = c;
            end
        end
        checks++;
        if (newg != 5) begin
            failures++;
            $display("FAIL disable_next_grant got=%0d exp=5", newg);
        end
        i_channel_en[2] = 1'b1;
        resumed = 1'b0;
        for (int i = 0; i < 40 && !drained(); i++) begin
            step();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL reenable_model cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
            end
            if (acc_valid && !resumed) begin
                resumed = 1'b1;
                checks++;
                if (acc_id !== IDW'(2) || acc_data !== mem[2][2]) begin
                    failures++;
                    $display("FAIL reenable_word got=ch%0d %h exp=ch2 %h", acc_id, acc_data, mem[2][2]);
                end
            end
        end
        checks++;
        if (!resumed || head[2] != tail[2]) begin
            failures++;
            $display("FAIL reenable_drain got=left%0d exp=left0", tail[2] - head[2]);
        end
    endtask

    task automatic test_reset_mid_burst();
        int p7, k;
        bit first_seen;
        do_reset();
        for (int j = 0; j < 8; j++) push(7, $urandom);
        rst_all = 1'b0;
        i_ready = 1'b1;
        p7 = 0;
        for (int i = 0; i < 20 && p7 < 2; i++) begin
            step();
            if (obs_rd[7]) p7++;
        end
        rst_all = 1'b1;
        step();
        checks++;
        if (obs_rd !== '0 || obs_v !== exp_v) begin
            failures++;
            $display("FAIL rstmid_reset_cycle got=%h exp=%h", obs_v, exp_v);
        end
        rst_all = 1'b0;
        step();
        checks++;
        if (obs_v !== '0) begin
            failures++;
            $display("FAIL rstmid_zero got=%h exp=0", obs_v);
        end
        k = 2;
        first_seen = 1'b0;
        for (int i = 0; i < 40 && !drained(); i++) begin
            step();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL rstmid_model cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
            end
            if (acc_valid) begin
                checks++;
                if (acc_data !== mem[7][k] || acc_id !== IDW'(7)) begin
                    failures++;
                    $display("FAIL rstmid_resume word=%0d got=ch%0d %h exp=ch7 %h", k, acc_id, acc_data, mem[7][k]);
                end
                k++;
                first_seen = 1'b1;
            end
        end
        checks++;
        if (!first_seen || k != 8) begin
            failures++;
            $display("FAIL rstmid_count got=%0d exp=8", k);
        end
    endtask

    task automatic test_random();
        do_reset();
        rst_all = 1'b0;
        i_channel_en = '1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) push($urandom_range(0, N - 1), $urandom);
            if ($urandom_range(0, 99) == 0) i_channel_en[$urandom_range(0, N - 1)] ^= 1'b1;
            i_ready = ($urandom_range(0, 3) != 0);
            rst_all = ($urandom_range(0, 399) == 0);
            step();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL random_model cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
            end
        end
        rst_all = 1'b0;
        i_ready = 1'b1;
        i_channel_en = '1;
        for (int i = 0; i < 3000 && !drained(); i++) begin
            step();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL random_drain_model cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
            end
        end
        checks++;
        if (!drained()) begin
            failures++;
            $display("FAIL random_drain got=not_drained exp=drained");
        end
    endtask

    initial begin
        rst_all = 1'b1;
        i_ready = 1'b1;
        i_channel_en = '1;
        i_rd_valid_channels = '0;
        i_rd_data_channels = '0;
        flush();
        test_reset();
        test_single_channel();
        test_round_robin_wrap();
        test_backpressure();
        test_disable_mid_burst();
        test_reset_mid_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
